// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encodings and default width.
package serial_adder_pkg;

  // Operand/result width used when the instantiating code does not override it.
  localparam int unsigned DEFAULT_WIDTH = 8;

  // Controller states; the unused 2'd3 encoding is steered back to S_IDLE.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder built from two half-adder cells and an OR gate.
// Purely combinational; time-multiplexed by serial_adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic ha0_sum_s;
  logic ha0_carry_s;
  logic ha1_sum_s;
  logic ha1_carry_s;

  // First half-adder cell: combines the two operand bits.
  assign ha0_sum_s   = a ^ b;
  assign ha0_carry_s = a & b;

  // Second half-adder cell: folds in the incoming carry.
  assign ha1_sum_s   = ha0_sum_s ^ cin;
  assign ha1_carry_s = ha0_sum_s & cin;

  // A carry out of either cell is the full-adder carry (they never both fire).
  assign sum  = ha1_sum_s;
  assign cout = ha0_carry_s | ha1_carry_s;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial, LSB-first adder. One full-adder cell is reused over WIDTH
// clock cycles with a registered carry; result and carry-out are registered
// and held until the next completion.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   areg_q, areg_d;
  logic [WIDTH-1:0]   breg_q, breg_d;
  // Only the upper WIDTH-1 partial-sum bits need storage: the newest sum bit
  // is supplied directly by the adder on the final step.
  logic [WIDTH-2:0]   psum_q, psum_d;
  logic               carry_q, carry_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               cout_q, cout_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               fa_sum_s;
  logic               fa_cout_s;
  logic [WIDTH-1:0]   sum_shift_s;

  // The single time-shared full-adder cell works on the current LSBs.
  full_adder u_fa (
    .a    (areg_q[0]),
    .b    (breg_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum_s),
    .cout (fa_cout_s)
  );

  // New sum bit enters at the top; after WIDTH steps the LSB has reached bit 0.
  assign sum_shift_s = {fa_sum_s, psum_q};

  // Next-state, datapath and output-flag computation for the controller.
  always_comb begin
    state_d  = state_q;
    areg_d   = areg_q;
    breg_d   = breg_q;
    psum_d   = psum_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    cout_d   = cout_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          areg_d  = a_in;
          breg_d  = b_in;
          psum_d  = '0;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        areg_d  = {1'b0, areg_q[WIDTH-1:1]};
        breg_d  = {1'b0, breg_q[WIDTH-1:1]};
        psum_d  = sum_shift_s[WIDTH-1:1];
        carry_d = fa_cout_s;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          result_d = sum_shift_s;
          cout_d   = fa_cout_s;
          state_d  = S_DONE;
        end else begin
          state_d  = S_SHIFT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Flags are registered from the next state so they line up with it.
    busy_d = (state_d == S_SHIFT);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers; synchronous reset aborts any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      areg_q   <= '0;
      breg_q   <= '0;
      psum_q   <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      areg_q   <= areg_d;
      breg_q   <= breg_d;
      psum_q   <= psum_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: scoreboard queue filled at issue time,
// monitor compares on every done pulse and checks that results are held.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;

  int total = 0;
  int bad   = 0;

  logic [W:0] exp_q[$];
  logic [W:0] held = '0;
  logic       rst_s = 1'b1;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a_in   (a_in),
    .b_in   (b_in),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain unsigned addition, carry-out is bit W of the sum.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned s;
    s = int'(a) + int'(b);
    return s[W:0];
  endfunction

  // Remember whether reset was sampled at the last rising edge.
  always @(posedge clk) rst_s <= rst;

  // Monitor: reset values, scoreboard compare on done, hold otherwise.
  always @(negedge clk) begin
    logic [W:0] e;
    if (rst_s) begin
      check("reset_outputs", {busy, done, cout, result}, '0);
      held = '0;
    end else if (done) begin
      if (exp_q.size() == 0) begin
        check("done_without_op", done, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("sum_cout", {cout, result}, e);
        held = e;
      end
    end else begin
      check("result_held", {cout, result}, held);
    end
  end

  // Present operands and start; returns one tick after the accepting edge.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit push, input bit hold);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    if (push) exp_q.push_back(model(a, b));
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  // Wait (bounded) for the done pulse and check busy length and latency.
  task automatic complete(input bit wiggle);
    int lat  = 0;
    int bcnt = 0;
    bit got  = 1'b0;
    for (int k = 1; k <= W + 6 && !got; k++) begin
      if (wiggle) begin
        a_in = W'($urandom);
        b_in = W'($urandom);
      end
      @(negedge clk);
      if (busy) bcnt++;
      if (done) begin
        got = 1'b1;
        lat = k;
      end
      @(posedge clk);
      #1;
    end
    check("done_seen", got, 1'b1);
    check("done_latency", lat, W + 1);
    check("busy_cycles", bcnt, W);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no end expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic add and carry out of the top bit.
    launch(8'h05, 8'h03, 1'b1, 1'b0);
    complete(1'b0);
    launch(8'hFF, 8'h01, 1'b1, 1'b0);
    complete(1'b0);

    // Start held high: one done, then a fresh op only once back in IDLE.
    launch(8'hAA, 8'h55, 1'b1, 1'b1);
    complete(1'b0);
    exp_q.push_back(model(8'hAA, 8'h55));
    @(posedge clk);
    #1;
    start = 1'b0;
    complete(1'b0);

    // Abort mid-shift with reset: no done, outputs cleared.
    launch(8'h10, 8'h20, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 1'b0);
    repeat (W + 4) @(posedge clk);
    #1;
    check("abort_result", {cout, result}, '0);
    launch(8'h01, 8'h01, 1'b1, 1'b0);
    complete(1'b0);

    // Reset and start together: reset wins, nothing starts.
    a_in  = 8'h33;
    b_in  = 8'h44;
    start = 1'b1;
    rst   = 1'b1;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("rst_start_busy", busy, 1'b0);
    repeat (W + 3) @(posedge clk);
    #1;

    // Back-to-back: second start in the first IDLE cycle.
    launch(8'h80, 8'h80, 1'b1, 1'b0);
    complete(1'b0);
    launch(8'h7F, 8'h01, 1'b1, 1'b0);
    complete(1'b0);

    // Operand inputs toggling during the shift must not matter.
    launch(8'h0F, 8'hF0, 1'b1, 1'b0);
    complete(1'b1);

    // Randomized operands with random idle gaps.
    for (int i = 0; i < 24; i++) begin
      launch(W'($urandom), W'($urandom), 1'b1, 1'b0);
      complete(i % 3 == 0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (2) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
